// File: rtl/system_pkg.sv
// Shared AHB-Lite constants and types for the Ibex bus arbiter.
package system_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] haddr;
        logic [2:0]            hsize;
        logic                  hwrite;
        logic [3:0]            hprot;
    } ahbl_addr_t;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

endpackage

// File: rtl/ahbl_arb_port.sv
// Per-master side of the arbiter: one-entry address hold register, request
// generation and HREADY/HRESP stretching toward the master.
module ahbl_arb_port
    import system_pkg::*;
(
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [ADDR_WIDTH-1:0]        haddr_i,
    input  logic [2:0]                   hsize_i,
    input  logic [1:0]                   htrans_i,
    input  logic                         hwrite_i,
    input  logic [3:0]                   hprot_i,
    input  logic                         grant_i,
    input  logic                         bus_ready_i,
    input  logic                         bus_resp_i,
    input  logic                         dp_mine_i,
    output logic                         req_o,
    output logic [$bits(ahbl_addr_t)-1:0] addr_o,
    output logic                         hready_o,
    output logic                         hresp_o
);

    ahbl_addr_t live;
    ahbl_addr_t hold_q, hold_d;
    logic       pend_q, pend_d;
    logic       live_req;
    logic       unused_htrans;

    // SEQ collapses to NONSEQ and BUSY to IDLE, so only htrans[1] matters.
    assign unused_htrans = htrans_i[0];

    always_comb begin
        live.haddr  = haddr_i;
        live.hsize  = hsize_i;
        live.hwrite = hwrite_i;
        live.hprot  = hprot_i;

        hready_o = dp_mine_i ? bus_ready_i : ~pend_q;
        hresp_o  = dp_mine_i & bus_resp_i;
        live_req = htrans_i[1] & hready_o;
        req_o    = live_req | pend_q;
        addr_o   = pend_q ? hold_q : live;

        pend_d = pend_q;
        hold_d = hold_q;
        if (grant_i) begin
            pend_d = 1'b0;
        end else if (live_req) begin
            pend_d = 1'b1;
            hold_d = live;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= 1'b0;
            hold_q <= '0;
        end else begin
            pend_q <= pend_d;
            hold_q <= hold_d;
        end
    end

endmodule

// File: rtl/ahbl_dual_master_arbiter.sv
// Two-master to one-slave AHB-Lite arbiter for the Ibex instruction and data
// ports; grant logic, data-phase ownership and shared-bus muxes live here.
module ahbl_dual_master_arbiter
    import system_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic                  sys_clk_i,
    input  logic                  sys_rstn_i,
    input  logic [ADDR_WIDTH-1:0] s0_haddr_i,
    input  logic [2:0]            s0_hsize_i,
    input  logic [1:0]            s0_htrans_i,
    input  logic                  s0_hwrite_i,
    input  logic [3:0]            s0_hprot_i,
    input  logic [DATA_WIDTH-1:0] s0_hwdata_i,
    output logic [DATA_WIDTH-1:0] s0_hrdata_o,
    output logic                  s0_hready_o,
    output logic                  s0_hresp_o,
    input  logic [ADDR_WIDTH-1:0] s1_haddr_i,
    input  logic [2:0]            s1_hsize_i,
    input  logic [1:0]            s1_htrans_i,
    input  logic                  s1_hwrite_i,
    input  logic [3:0]            s1_hprot_i,
    input  logic [DATA_WIDTH-1:0] s1_hwdata_i,
    output logic [DATA_WIDTH-1:0] s1_hrdata_o,
    output logic                  s1_hready_o,
    output logic                  s1_hresp_o,
    output logic [ADDR_WIDTH-1:0] m_haddr_o,
    output logic [2:0]            m_hsize_o,
    output logic [1:0]            m_htrans_o,
    output logic                  m_hwrite_o,
    output logic [3:0]            m_hprot_o,
    output logic [DATA_WIDTH-1:0] m_hwdata_o,
    output logic [2:0]            m_hburst_o,
    output logic                  m_hmastlock_o,
    input  logic [DATA_WIDTH-1:0] m_hrdata_i,
    input  logic                  m_hready_i,
    input  logic                  m_hresp_i
);

    ahbl_addr_t addr0, addr1, sel;
    logic       req0, req1, pick1, gnt0, gnt1;
    logic       dp_mine0, dp_mine1;
    logic       dp_valid_q, dp_valid_d;
    port_e      owner_q, owner_d;
    port_e      last_q, last_d;

    assign dp_mine0 = dp_valid_q & (owner_q == PORT0);
    assign dp_mine1 = dp_valid_q & (owner_q == PORT1);

    ahbl_arb_port u_port0 (
        .clk_i       (sys_clk_i),
        .rst_ni      (sys_rstn_i),
        .haddr_i     (s0_haddr_i),
        .hsize_i     (s0_hsize_i),
        .htrans_i    (s0_htrans_i),
        .hwrite_i    (s0_hwrite_i),
        .hprot_i     (s0_hprot_i),
        .grant_i     (gnt0),
        .bus_ready_i (m_hready_i),
        .bus_resp_i  (m_hresp_i),
        .dp_mine_i   (dp_mine0),
        .req_o       (req0),
        .addr_o      (addr0),
        .hready_o    (s0_hready_o),
        .hresp_o     (s0_hresp_o)
    );

    ahbl_arb_port u_port1 (
        .clk_i       (sys_clk_i),
        .rst_ni      (sys_rstn_i),
        .haddr_i     (s1_haddr_i),
        .hsize_i     (s1_hsize_i),
        .htrans_i    (s1_htrans_i),
        .hwrite_i    (s1_hwrite_i),
        .hprot_i     (s1_hprot_i),
        .grant_i     (gnt1),
        .bus_ready_i (m_hready_i),
        .bus_resp_i  (m_hresp_i),
        .dp_mine_i   (dp_mine1),
        .req_o       (req1),
        .addr_o      (addr1),
        .hready_o    (s1_hready_o),
        .hresp_o     (s1_hresp_o)
    );

    always_comb begin
        // On a tie, round-robin favours whichever port did not win last time.
        if (req0 && req1) begin
            pick1 = RR_EN ? (last_q == PORT0) : 1'b0;
        end else begin
            pick1 = req1;
        end
        gnt0 = m_hready_i & req0 & ~pick1;
        gnt1 = m_hready_i & req1 & pick1;

        last_d     = last_q;
        owner_d    = owner_q;
        dp_valid_d = dp_valid_q;
        if (m_hready_i) begin
            dp_valid_d = gnt0 | gnt1;
            if (gnt0 || gnt1) begin
                last_d  = gnt1 ? PORT1 : PORT0;
                owner_d = gnt1 ? PORT1 : PORT0;
            end
        end

        sel = gnt1 ? addr1 : addr0;
        if (gnt0 || gnt1) begin
            m_htrans_o = HTRANS_NONSEQ;
            m_haddr_o  = sel.haddr;
            m_hsize_o  = sel.hsize;
            m_hwrite_o = sel.hwrite;
            m_hprot_o  = sel.hprot;
        end else begin
            m_htrans_o = HTRANS_IDLE;
            m_haddr_o  = '0;
            m_hsize_o  = '0;
            m_hwrite_o = 1'b0;
            m_hprot_o  = '0;
        end

        if (dp_valid_q) begin
            m_hwdata_o = (owner_q == PORT1) ? s1_hwdata_i : s0_hwdata_i;
        end else begin
            m_hwdata_o = '0;
        end
    end

    assign s0_hrdata_o   = m_hrdata_i;
    assign s1_hrdata_o   = m_hrdata_i;
    assign m_hburst_o    = HBURST_SINGLE;
    assign m_hmastlock_o = 1'b0;

    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            dp_valid_q <= 1'b0;
            owner_q    <= PORT0;
            last_q     <= PORT1;
        end else begin
            dp_valid_q <= dp_valid_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
        end
    end

endmodule

// File: doc/ahbl_dual_master_arbiter.md
# ahbl_dual_master_arbiter

Two-master to one-slave AHB-Lite arbiter that lets the Ibex core's instruction-side and data-side AHB-Lite master ports share a single downstream AHB-Lite bus. It sits between the core's bus bridge and the system interconnect. It accepts single transfers from either port and stores a losing port's address phase in a one-entry holding register. It stretches each master's HREADY so that neither master sees a dropped or reordered transfer.

## Interface
- `RR_EN`, default 1: 1 = round-robin on contention; 0 = fixed priority, port 0 always wins.
- `ADDR_WIDTH`, `DATA_WIDTH`: from `system_pkg`, both 32.
- `sys_clk_i`, in, 1: single clock.
- `sys_rstn_i`, in, 1: asynchronous, active-low reset.
- `s0_haddr_i`, `s0_hsize_i`, `s0_htrans_i`, `s0_hwrite_i`, `s0_hprot_i`, `s0_hwdata_i`, in: port 0 (data master) request. Widths are `ADDR_WIDTH`, 3, 2, 1, 4 and `DATA_WIDTH`.
- `s0_hrdata_o`, `s0_hready_o`, `s0_hresp_o`, out, `DATA_WIDTH`/1/1: port 0 response.
- `s1_*`: the same set for port 1 (instruction master).
- `m_haddr_o`, `m_hsize_o`, `m_htrans_o`, `m_hwrite_o`, `m_hprot_o`, `m_hwdata_o`, out: shared-bus request.
- `m_hburst_o`, out, 3: constant SINGLE (3'b000).
- `m_hmastlock_o`, out, 1: constant 0.
- `m_hrdata_i`, `m_hready_i`, `m_hresp_i`, in: shared-bus response.

## Operation
- **Request.** Port i requests when `si_htrans_i[1]`=1 and `si_hready_o`=1, or when its hold register is valid (`pend_i`).
  - SEQ is treated as NONSEQ.
  - BUSY is treated as IDLE.
  - `m_htrans_o` is only ever IDLE or NONSEQ.
- **Arbitration.** Happens only in cycles with `m_hready_i`=1.
  - One requester: that port is granted.
  - Two requesters, `RR_EN`=1: the port not granted last is granted.
  - Two requesters, `RR_EN`=0: port 0 is granted.
  - `last_grant` updates on every grant.
- **Grant source.** The granted port drives `m_*` combinationally, from its hold register if `pend_i`, otherwise from its live inputs. `m_htrans_o`=NONSEQ.
- **No grant.** `m_htrans_o`=IDLE, `m_haddr_o`=0, `m_hwrite_o`=0.
- **Capture.** If port i has a live request with `si_hready_o`=1 and is not granted this cycle (lost, or `m_hready_i`=0):
  - haddr, hsize, hwrite and hprot are latched into hold register i.
  - `pend_i` is set.
- **Pending clear.** `pend_i` clears when the held transfer is granted.
- **Data-phase tracking.** On grant with `m_hready_i`=1: `dp_valid`<=1 and `dp_owner`<=granted port. With `m_hready_i`=1 and no grant: `dp_valid`<=0.
- **`si_hready_o`.**
  - `m_hready_i` if `dp_valid` and `dp_owner`=i.
  - Otherwise 0 if `pend_i`.
  - Otherwise 1.
- **`si_hresp_o`.** `m_hresp_i` if `dp_valid` and `dp_owner`=i, else 0. A two-cycle ERROR passes through unchanged.
- **Read data.** `si_hrdata_o` = `m_hrdata_i` for both ports; it is meaningful only to the data-phase owner.
- **Write data.** `m_hwdata_o` = `s<dp_owner>_hwdata_i` when `dp_valid`, else 0. A pending master holds hwdata stable because its HREADY is low.

## Timing
- **Reset values.**
  - `m_htrans_o`=IDLE; `m_haddr_o`, `m_hwdata_o` and `m_hwrite_o` are 0.
  - `si_hready_o`=1, `si_hresp_o`=0.
  - `pend_i`=0, `dp_valid`=0, `last_grant`=1, so port 0 wins the first tie.
- **Latency.**
  - Uncontended, bus ready: zero added cycles; the address passes through combinationally.
  - Captured transfer: issued in the first later cycle in which `m_hready_i`=1 and the port wins.
- **Fairness.** A pending port under round-robin waits at most one transfer.
- **Back-to-back.** A port whose data phase completes (`m_hready_i`=1) may present its next address in the same cycle. That address is granted directly or captured; it is never lost.
- **Stall.** `m_hready_i`=0 blocks arbitration. A live request from an idle port is captured, not dropped.
- **Reset mid-transfer.** All state clears asynchronously; pending and in-flight transfers are abandoned.
- **Invariant.** At most one hold entry per port, and at most one transfer in each of the bus's address and data phases.

## Structure
- `system_pkg` gains:
  - `HTRANS_IDLE`, `HTRANS_NONSEQ` and `HBURST_SINGLE` constants;
  - an `ahbl_addr_t` struct {haddr, hsize, hwrite, hprot} used for the hold registers and mux.
- Sub-module `ahbl_arb_port`, instantiated twice, contains:
  - the hold register;
  - `pend` generation;
  - request generation;
  - `hready`/`hresp` generation.
- The top level contains the grant logic, `last_grant`, `dp_owner`/`dp_valid` and the `m_*` muxes.

## Test plan
- **Single read.** Port 1 NONSEQ read to 0x0000_0100, slave returns 0xDEAD_BEEF with no wait states.
  - Response: `m_htrans_o`=NONSEQ in cycle 0; `s1_hrdata_o`=0xDEAD_BEEF with `s1_hready_o`=1 in cycle 1; port 0 untouched.
- **Simultaneous requests, `RR_EN`=1.** Port 0 writes 0x1234_5678 to 0x2000_0000 while port 1 reads 0x0000_0004, both in cycle 0, after reset.
  - Response: port 0 granted in cycle 0 and port 1 captured; port 1 issued in cycle 1; `s1_hready_o`=0 in cycle 1, then 1 in cycle 2.
- **Fixed priority, `RR_EN`=0.** Both ports request continuously for 4 transfers.
  - Response: port 0 gets every grant; port 1 stays pending with `s1_hready_o`=0.
- **Slave wait states.** Slave holds `m_hready_i`=0 for 3 cycles during a port 0 write, and port 1 requests in the first of those cycles.
  - Response: port 1 captured; `m_hwdata_o` stable at port 0's data; port 1 issued in the cycle `m_hready_i` returns to 1.
- **Error response.** Slave returns a two-cycle ERROR on a port 0 transfer.
  - Response: `s0_hresp_o`=1 in both cycles with `s0_hready_o`=0 then 1; `s1_hresp_o` stays 0 throughout.
- **Reset mid-transfer.** Assert `sys_rstn_i` low while port 1 is pending.
  - Response: all outputs return to their reset values immediately; no transfer issued after reset release.
